bp_fe_bht_updater: RTL and testbench

Update-side driver for the front-end branch history table. Records every direction prediction the FE issues (table index plus predicted direction) in an in-order queue, pairs each with its resolved outcome from the back end, and emits one registered BHT write (index, correct flag, predicted direction) per resolution. Sits between the FE prediction stage and the BHT write port; a flush discards all unresolved predictions.

---
 rtl/bp_fe_pkg.sv | 20 ++
 rtl/bp_fe_bht_updater_if.sv | 31 +++
 rtl/bp_fe_bht_pred_fifo.sv | 61 ++++++
 rtl/bp_fe_bht_updater.sv | 78 +++++++
 tb/tb_bp_fe_bht_updater.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end BHT update path.
// The entry width is taken from a macro so every user agrees on the index width.
`ifndef BP_FE_BHT_IDX_WIDTH
`define BP_FE_BHT_IDX_WIDTH 9
`endif

package bp_fe_pkg;

    localparam int unsigned bht_idx_width_gp = `BP_FE_BHT_IDX_WIDTH;

    typedef struct packed {
        logic [bht_idx_width_gp-1:0] idx;
        logic                        taken;
    } bp_fe_bht_pred_entry_s;

    function automatic logic pred_correct(input logic pred, input logic actual);
        return ~(pred ^ actual);
    endfunction

endpackage

// File: rtl/bp_fe_bht_updater_if.sv
// Prediction, resolution and BHT-write signals between FE/BE and the updater.
interface bp_fe_bht_updater_if #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned els_p           = 8
);
    localparam int unsigned cnt_w_lp = $clog2(els_p) + 1;

    logic                       pred_v_i;
    logic [bht_idx_width_p-1:0] pred_idx_i;
    logic                       pred_taken_i;
    logic                       pred_ready_o;
    logic                       res_v_i;
    logic                       res_taken_i;
    logic                       flush_i;
    logic                       w_v_o;
    logic [bht_idx_width_p-1:0] idx_w_o;
    logic                       correct_o;
    logic                       pred_taken_o;
    logic [cnt_w_lp-1:0]        count_o;

    modport master (
        output pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
        input  pred_ready_o, w_v_o, idx_w_o, correct_o, pred_taken_o, count_o
    );

    modport slave (
        input  pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
        output pred_ready_o, w_v_o, idx_w_o, correct_o, pred_taken_o, count_o
    );

endinterface

// File: rtl/bp_fe_bht_pred_fifo.sv
// Circular buffer of outstanding predictions with enq/deq and a clear that
// discards everything not yet dequeued.
module bp_fe_bht_pred_fifo
    import bp_fe_pkg::*;
#(
    parameter int unsigned els_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      enq_i,
    input  bp_fe_bht_pred_entry_s     enq_data_i,
    input  logic                      deq_i,
    input  logic                      clr_i,
    output bp_fe_bht_pred_entry_s     deq_data_o,
    output logic [$clog2(els_p):0]    count_o
);
    localparam int unsigned ptr_w_lp = $clog2(els_p);
    localparam int unsigned cnt_w_lp = ptr_w_lp + 1;

    bp_fe_bht_pred_entry_s mem_q [els_p];
    bp_fe_bht_pred_entry_s mem_d [els_p];
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (enq_i) begin
            mem_d[wptr_q] = enq_data_i;
            wptr_d        = wptr_q + ptr_w_lp'(1);
        end
        // Clear lands after any same-cycle dequeue: the read pointer jumps to
        // the write pointer, so the dequeue's increment is simply superseded.
        if (clr_i) begin
            rptr_d  = wptr_d;
            count_d = '0;
        end else begin
            rptr_d  = deq_i ? rptr_q + ptr_w_lp'(1) : rptr_q;
            count_d = count_q + cnt_w_lp'(enq_i) - cnt_w_lp'(deq_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < els_p; i++) mem_q[i] <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign deq_data_o = mem_q[rptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/bp_fe_bht_updater.sv
// Pairs each queued FE prediction with its in-order resolution and issues a
// registered BHT write (index, correct, predicted direction).
module bp_fe_bht_updater
    import bp_fe_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned els_p           = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    bp_fe_bht_updater_if.slave  bus
);
    localparam int unsigned cnt_w_lp = $clog2(els_p) + 1;

    logic                       enq, deq, pred_ready;
    logic [cnt_w_lp-1:0]        count;
    bp_fe_bht_pred_entry_s      enq_entry, deq_entry;

    logic                       w_v_q, w_v_d;
    logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
    logic                       correct_q, correct_d;
    logic                       pred_taken_q, pred_taken_d;

    // Readiness uses only registered occupancy; a resolution in the same
    // cycle never frees a slot early.
    always_comb begin
        pred_ready      = (count != cnt_w_lp'(els_p)) & ~bus.flush_i;
        enq             = bus.pred_v_i & pred_ready;
        deq             = bus.res_v_i & (count != '0);
        enq_entry.idx   = bus.pred_idx_i;
        enq_entry.taken = bus.pred_taken_i;
    end

    bp_fe_bht_pred_fifo #(.els_p(els_p)) fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_i      (enq),
        .enq_data_i (enq_entry),
        .deq_i      (deq),
        .clr_i      (bus.flush_i),
        .deq_data_o (deq_entry),
        .count_o    (count)
    );

    always_comb begin
        w_v_d        = deq;
        idx_w_d      = idx_w_q;
        correct_d    = correct_q;
        pred_taken_d = pred_taken_q;
        if (deq) begin
            idx_w_d      = deq_entry.idx;
            correct_d    = pred_correct(deq_entry.taken, bus.res_taken_i);
            pred_taken_d = deq_entry.taken;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_q        <= 1'b0;
            idx_w_q      <= '0;
            correct_q    <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            w_v_q        <= w_v_d;
            idx_w_q      <= idx_w_d;
            correct_q    <= correct_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    assign bus.pred_ready_o = pred_ready;
    assign bus.count_o      = count;
    assign bus.w_v_o        = w_v_q;
    assign bus.idx_w_o      = idx_w_q;
    assign bus.correct_o    = correct_q;
    assign bus.pred_taken_o = pred_taken_q;

endmodule

// File: tb/tb_bp_fe_bht_updater.sv
// Directed and scoreboard-checked stimulus for bp_fe_bht_updater.
module tb_bp_fe_bht_updater;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_fe_bht_updater_if #(.bht_idx_width_p(9), .els_p(8)) bus ();

    bp_fe_bht_updater #(.bht_idx_width_p(9), .els_p(8)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [8:0] idx, input logic cor, input logic pt);
        chk({tag, "_wv"}, 32'(bus.w_v_o), 32'd1);
        chk({tag, "_idx"}, 32'(bus.idx_w_o), 32'(idx));
        chk({tag, "_cor"}, 32'(bus.correct_o), 32'(cor));
        chk({tag, "_pt"}, 32'(bus.pred_taken_o), 32'(pt));
    endtask

    initial begin
        logic [8:0] e;
        logic [9:0] q[$];
        logic [9:0] head;
        logic       pv, pt, rv, rt, fl, exp_rdy, exp_deq;
        logic [8:0] pidx;

        bus.pred_v_i = 0; bus.pred_idx_i = '0; bus.pred_taken_i = 0;
        bus.res_v_i = 0; bus.res_taken_i = 0; bus.flush_i = 0;

        // Reset state
        #12;
        chk("rst_count", 32'(bus.count_o), 0);
        chk("rst_wv", 32'(bus.w_v_o), 0);
        @(negedge clk); rst_n = 1'b1;
        cyc();
        chk("idle_count", 32'(bus.count_o), 0);
        chk("idle_ready", 32'(bus.pred_ready_o), 1);
        chk("idle_wv", 32'(bus.w_v_o), 0);
        chk("idle_idx", 32'(bus.idx_w_o), 0);
        chk("idle_cor", 32'(bus.correct_o), 0);
        chk("idle_pt", 32'(bus.pred_taken_o), 0);

        // Resolution while empty is ignored
        bus.res_v_i = 1; bus.res_taken_i = 1;
        cyc();
        chk("empty_res_wv", 32'(bus.w_v_o), 0);
        chk("empty_res_count", 32'(bus.count_o), 0);
        bus.res_v_i = 0;

        // Two predictions, two resolutions
        bus.pred_v_i = 1; bus.pred_idx_i = 9'h005; bus.pred_taken_i = 1;
        cyc();
        chk("enq1_count", 32'(bus.count_o), 1);
        bus.pred_idx_i = 9'h01A; bus.pred_taken_i = 0;
        cyc();
        chk("enq2_count", 32'(bus.count_o), 2);
        chk("enq2_wv", 32'(bus.w_v_o), 0);
        bus.pred_v_i = 0;
        bus.res_v_i = 1; bus.res_taken_i = 1;
        cyc();
        chk_w("res1", 9'h005, 1, 1);
        chk("res1_count", 32'(bus.count_o), 1);
        cyc();
        chk_w("res2", 9'h01A, 0, 0);
        chk("res2_count", 32'(bus.count_o), 0);
        bus.res_v_i = 0;
        cyc();
        chk("pulse_end_wv", 32'(bus.w_v_o), 0);
        chk("hold_idx", 32'(bus.idx_w_o), 32'h01A);
        chk("hold_cor", 32'(bus.correct_o), 0);

        // Fill to 8 entries: idx 0x100+i, taken=i[0]
        for (int i = 0; i < 8; i++) begin
            bus.pred_v_i = 1; bus.pred_idx_i = 9'(9'h100 + i); bus.pred_taken_i = i[0];
            cyc();
        end
        bus.pred_v_i = 0;
        chk("full_count", 32'(bus.count_o), 8);
        chk("full_ready", 32'(bus.pred_ready_o), 0);
        // Full: same-cycle pred+res, pred is rejected
        bus.pred_v_i = 1; bus.pred_idx_i = 9'h1FF; bus.pred_taken_i = 1;
        bus.res_v_i = 1; bus.res_taken_i = 1;
        cyc();
        chk("full_rej_count", 32'(bus.count_o), 7);
        chk_w("full_deq", 9'h100, 0, 0);

        // 16 simultaneous enq/deq cycles across pointer wrap
        for (int k = 0; k < 16; k++) begin
            bus.pred_v_i = 1; bus.pred_idx_i = 9'(9'h080 + k); bus.pred_taken_i = k[0];
            bus.res_v_i = 1; bus.res_taken_i = k[1];
            cyc();
            e = (k < 7) ? 9'(9'h101 + k) : 9'(9'h080 + k - 7);
            chk_w("wrap", e, ~(e[0] ^ k[1]), e[0]);
            chk("wrap_count", 32'(bus.count_o), 7);
        end
        bus.pred_v_i = 0;

        // Drain four (0x89..0x8C), leaving 0x8D..0x8F
        bus.res_taken_i = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            e = 9'(9'h089 + k);
            chk_w("drain", e, ~e[0], e[0]);
        end
        chk("pre_flush_count", 32'(bus.count_o), 3);

        // Flush with same-cycle resolution and prediction
        bus.flush_i = 1; bus.res_taken_i = 1;
        bus.pred_v_i = 1; bus.pred_idx_i = 9'h055; bus.pred_taken_i = 0;
        #1;
        chk("flush_ready", 32'(bus.pred_ready_o), 0);
        cyc();
        chk_w("flush_res", 9'h08D, 1, 1);
        chk("flush_count", 32'(bus.count_o), 0);
        bus.flush_i = 0; bus.pred_v_i = 0;
        cyc();
        chk("post_flush_wv", 32'(bus.w_v_o), 0);
        chk("post_flush_count", 32'(bus.count_o), 0);
        bus.res_v_i = 0;

        // Async reset mid-stream
        bus.pred_v_i = 1; bus.pred_idx_i = 9'h033; bus.pred_taken_i = 1;
        cyc();
        bus.pred_idx_i = 9'h044;
        cyc();
        bus.pred_v_i = 0;
        bus.res_v_i = 1; bus.res_taken_i = 0;
        cyc();
        chk_w("pre_rst", 9'h033, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wv", 32'(bus.w_v_o), 0);
        chk("arst_count", 32'(bus.count_o), 0);
        chk("arst_idx", 32'(bus.idx_w_o), 0);
        cyc();
        chk("arst_hold_wv", 32'(bus.w_v_o), 0);
        bus.res_v_i = 0;
        @(negedge clk); rst_n = 1'b1;
        cyc();
        chk("arst_rel_wv", 32'(bus.w_v_o), 0);
        chk("arst_rel_count", 32'(bus.count_o), 0);
        chk("arst_rel_ready", 32'(bus.pred_ready_o), 1);

        // Random traffic against a scoreboard queue
        for (int n = 0; n < 4000; n++) begin
            pv   = ($urandom_range(0, 3) != 0);
            pidx = 9'($urandom);
            pt   = 1'($urandom);
            rv   = ($urandom_range(0, 2) != 0);
            rt   = 1'($urandom);
            fl   = ($urandom_range(0, 40) == 0);
            bus.pred_v_i = pv; bus.pred_idx_i = pidx; bus.pred_taken_i = pt;
            bus.res_v_i = rv; bus.res_taken_i = rt; bus.flush_i = fl;
            #1;
            exp_rdy = (q.size() != 8) && !fl;
            chk("rnd_count", 32'(bus.count_o), 32'(q.size()));
            chk("rnd_ready", 32'(bus.pred_ready_o), 32'(exp_rdy));
            exp_deq = rv && (q.size() != 0);
            head = '0;
            if (exp_deq) head = q.pop_front();
            if (fl) q.delete();
            if (pv && exp_rdy) q.push_back({pidx, pt});
            cyc();
            if (exp_deq) chk_w("rnd_w", head[9:1], ~(head[0] ^ rt), head[0]);
            else chk("rnd_nowv", 32'(bus.w_v_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
